// File: rtl/vga_sync_receiver.sv
// VGA receive-side timing recovery: measures line length and frame height, locks on
// stable timing and emits registered active-area pixels with X/Y coordinates.
module vga_sync_receiver #(
  parameter int unsigned H_ACT   = 640,
  parameter int unsigned V_ACT   = 480,
  parameter int unsigned X_START = 143,
  parameter int unsigned Y_START = 34,
  parameter int unsigned CW      = 11
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iVGA_H_SYNC,
  input  logic          iVGA_V_SYNC,
  input  logic [7:0]    iVGA_R,
  input  logic [7:0]    iVGA_G,
  input  logic [7:0]    iVGA_B,
  output logic [7:0]    oRed,
  output logic [7:0]    oGreen,
  output logic [7:0]    oBlue,
  output logic [CW-1:0] oX,
  output logic [CW-1:0] oY,
  output logic          oValid,
  output logic          oFrameStart,
  output logic          oLocked,
  output logic          oLockLost,
  output logic [CW-1:0] oLineLen,
  output logic [CW-1:0] oFrameLines
);

  localparam logic [CW-1:0] C_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] C_X_START = CW'(X_START);
  localparam logic [CW-1:0] C_X_END   = CW'(X_START + H_ACT);
  localparam logic [CW-1:0] C_Y_START = CW'(Y_START);
  localparam logic [CW-1:0] C_Y_END   = CW'(Y_START + V_ACT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MEAS   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_hs_q;
  logic          r_vs_q;
  logic [CW-1:0] r_p;
  logic [CW-1:0] r_l;
  logic [CW-1:0] r_ref_len;
  logic [CW-1:0] r_ref_lines;
  logic          r_ref_valid;

  logic          w_le;
  logic          w_fs;
  logic          w_p_sat;
  logic          w_pix;
  logic          w_lost;
  logic          w_frame_start;
  logic          w_locked_nxt;
  logic          w_ref_valid_nxt;
  logic [CW-1:0] w_line_len;
  logic [CW-1:0] w_height;
  logic [CW-1:0] w_p_nxt;
  logic [CW-1:0] w_l_nxt;
  logic [CW-1:0] w_ref_len_nxt;
  logic [CW-1:0] w_ref_lines_nxt;

  // Edge detection and saturating position/line counters for the current sample
  assign w_le       = ~iVGA_H_SYNC & r_hs_q;
  assign w_fs       = w_le & ~iVGA_V_SYNC & r_vs_q;
  assign w_line_len = (r_p == C_MAX) ? C_MAX : r_p + C_ONE;
  assign w_height   = (r_l == C_MAX) ? C_MAX : r_l + C_ONE;
  assign w_p_nxt    = w_le ? '0 : w_line_len;
  assign w_l_nxt    = w_fs ? '0 : (w_le ? w_height : r_l);
  assign w_p_sat    = (w_p_nxt == C_MAX);

  // Active window uses the pre-update state; unlocking samples always sit outside it
  assign w_pix = (r_state == S_LOCKED) &&
                 (w_p_nxt >= C_X_START) && (w_p_nxt < C_X_END) &&
                 (w_l_nxt >= C_Y_START) && (w_l_nxt < C_Y_END);

  assign w_locked_nxt = (w_state_nxt == S_LOCKED);

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ref_len_nxt   = r_ref_len;
    w_ref_lines_nxt = r_ref_lines;
    w_ref_valid_nxt = r_ref_valid;
    w_lost          = 1'b0;
    w_frame_start   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fs) begin
          w_state_nxt     = S_MEAS;
          w_ref_valid_nxt = 1'b0;
        end
      end
      S_MEAS: begin
        if (w_p_sat) begin
          w_state_nxt = S_IDLE;
        end else if (w_le) begin
          if (r_ref_valid && (w_line_len != r_ref_len)) begin
            w_state_nxt = S_IDLE;
          end else if (w_fs) begin
            w_ref_lines_nxt = w_height;
            if (r_ref_valid && (r_ref_len >= C_X_END) && (w_height >= C_Y_END)) begin
              w_state_nxt   = S_LOCKED;
              w_frame_start = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else if (!r_ref_valid) begin
            w_ref_len_nxt   = w_line_len;
            w_ref_valid_nxt = 1'b1;
          end
        end
      end
      S_LOCKED: begin
        if (w_p_sat || (w_le && (w_line_len != r_ref_len)) ||
            (w_fs && (w_height != r_ref_lines))) begin
          w_state_nxt = S_IDLE;
          w_lost      = 1'b1;
        end else if (w_fs) begin
          w_frame_start = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sync history, counters, references and registered outputs
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_hs_q      <= 1'b1;
      r_vs_q      <= 1'b1;
      r_p         <= '0;
      r_l         <= '0;
      r_ref_len   <= '0;
      r_ref_lines <= '0;
      r_ref_valid <= 1'b0;
      oValid      <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oRed        <= '0;
      oGreen      <= '0;
      oBlue       <= '0;
      oFrameStart <= 1'b0;
      oLocked     <= 1'b0;
      oLockLost   <= 1'b0;
      oLineLen    <= '0;
      oFrameLines <= '0;
    end else begin
      r_hs_q <= iVGA_H_SYNC;
      if (w_le) begin
        r_vs_q <= iVGA_V_SYNC;
      end
      r_p         <= w_p_nxt;
      r_l         <= w_l_nxt;
      r_ref_len   <= w_ref_len_nxt;
      r_ref_lines <= w_ref_lines_nxt;
      r_ref_valid <= w_ref_valid_nxt;
      oValid      <= w_pix;
      oX          <= w_pix ? (w_p_nxt - C_X_START) : '0;
      oY          <= w_pix ? (w_l_nxt - C_Y_START) : '0;
      oRed        <= w_pix ? iVGA_R : '0;
      oGreen      <= w_pix ? iVGA_G : '0;
      oBlue       <= w_pix ? iVGA_B : '0;
      oFrameStart <= w_frame_start;
      oLocked     <= w_locked_nxt;
      oLockLost   <= w_lost;
      oLineLen    <= w_locked_nxt ? w_ref_len_nxt : '0;
      oFrameLines <= w_locked_nxt ? w_ref_lines_nxt : '0;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: randomized sync/pixel streams against a cycle-level
// reference model plus frame-level checks (pixel count, corner coordinates, lock timing).
module tb_vga_sync_receiver;

  localparam int H_ACT     = 16;
  localparam int V_ACT     = 6;
  localparam int X_START   = 5;
  localparam int Y_START   = 3;
  localparam int CW        = 11;
  localparam int X_END     = X_START + H_ACT;
  localparam int Y_END     = Y_START + V_ACT;
  localparam int MAXV      = (1 << CW) - 1;
  localparam int NOM_LEN   = 28;
  localparam int NOM_HS    = 4;
  localparam int NOM_LINES = 12;
  localparam int VS_LOW    = 2;
  localparam int M_IDLE    = 0;
  localparam int M_MEAS    = 1;
  localparam int M_LOCK    = 2;

  logic          clk;
  logic          iRST_N;
  logic          iVGA_H_SYNC;
  logic          iVGA_V_SYNC;
  logic [7:0]    iVGA_R;
  logic [7:0]    iVGA_G;
  logic [7:0]    iVGA_B;
  logic [7:0]    oRed;
  logic [7:0]    oGreen;
  logic [7:0]    oBlue;
  logic [CW-1:0] oX;
  logic [CW-1:0] oY;
  logic          oValid;
  logic          oFrameStart;
  logic          oLocked;
  logic          oLockLost;
  logic [CW-1:0] oLineLen;
  logic [CW-1:0] oFrameLines;

  vga_sync_receiver #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .X_START(X_START), .Y_START(Y_START), .CW(CW)
  ) dut (
    .iCLK(clk), .iRST_N(iRST_N), .iVGA_H_SYNC(iVGA_H_SYNC), .iVGA_V_SYNC(iVGA_V_SYNC),
    .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oX(oX), .oY(oY),
    .oValid(oValid), .oFrameStart(oFrameStart), .oLocked(oLocked),
    .oLockLost(oLockLost), .oLineLen(oLineLen), .oFrameLines(oFrameLines)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (plain integers, -1 marks an unloaded line reference)
  int m_hs_prev, m_vs_prev, m_pos, m_line, m_mode, m_ref_len, m_ref_lines;
  logic          e_valid, e_fs, e_locked, e_lost;
  logic [CW-1:0] e_x, e_y, e_len, e_lines;
  logic [7:0]    e_r, e_g, e_b;
  bit            have_exp = 1'b0;

  // Frame-level observation state
  bit            map_mode = 1'b0;
  bit            armed = 1'b0;
  bit            locked_seen = 1'b0;
  int            pix_cnt = 0;
  int            lost_cnt = 0;
  logic [CW-1:0] last_x, last_y;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst_n, input logic hs, input logic vs,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bit le_s, fs_s, in_win;
    int len, height, pos, line;
    e_lost = 1'b0;
    e_fs   = 1'b0;
    if (!rst_n) begin
      m_hs_prev = 1; m_vs_prev = 1; m_pos = 0; m_line = 0;
      m_mode = M_IDLE; m_ref_len = -1; m_ref_lines = 0;
      {e_valid, e_locked} = 2'b00;
      {e_x, e_y, e_len, e_lines} = '0;
      {e_r, e_g, e_b} = '0;
      return;
    end
    le_s   = (hs == 1'b0) && (m_hs_prev == 1);
    fs_s   = le_s && (vs == 1'b0) && (m_vs_prev == 1);
    len    = (m_pos + 1 > MAXV) ? MAXV : m_pos + 1;
    height = (m_line + 1 > MAXV) ? MAXV : m_line + 1;
    pos    = le_s ? 0 : len;
    line   = fs_s ? 0 : (le_s ? height : m_line);
    in_win = (m_mode == M_LOCK) && pos >= X_START && pos < X_END &&
             line >= Y_START && line < Y_END;
    e_valid = in_win;
    e_x = in_win ? CW'(pos - X_START) : '0;
    e_y = in_win ? CW'(line - Y_START) : '0;
    e_r = in_win ? r : 8'h00;
    e_g = in_win ? g : 8'h00;
    e_b = in_win ? b : 8'h00;
    case (m_mode)
      M_IDLE: if (fs_s) begin m_mode = M_MEAS; m_ref_len = -1; end
      M_MEAS: begin
        if (pos == MAXV) m_mode = M_IDLE;
        else if (le_s) begin
          if (m_ref_len >= 0 && len != m_ref_len) m_mode = M_IDLE;
          else if (fs_s) begin
            m_ref_lines = height;
            if (m_ref_len >= X_END && height >= Y_END) begin
              m_mode = M_LOCK; e_fs = 1'b1;
            end else m_mode = M_IDLE;
          end else if (m_ref_len < 0) m_ref_len = len;
        end
      end
      default: begin
        if (pos == MAXV || (le_s && len != m_ref_len) || (fs_s && height != m_ref_lines)) begin
          m_mode = M_IDLE; e_lost = 1'b1;
        end else if (fs_s) e_fs = 1'b1;
      end
    endcase
    m_hs_prev = int'(hs);
    if (le_s) m_vs_prev = int'(vs);
    m_pos  = pos;
    m_line = line;
    e_locked = (m_mode == M_LOCK);
    e_len    = e_locked ? CW'(m_ref_len) : '0;
    e_lines  = e_locked ? CW'(m_ref_lines) : '0;
  endtask

  // Frame-level properties observed on the DUT outputs
  task automatic monitor();
    if (oLocked) locked_seen = 1'b1;
    if (oLockLost) lost_cnt++;
    if (!oLocked || oLockLost) armed = 1'b0;
    if (oFrameStart) begin
      if (armed) begin
        check("frame_pix", 64'(pix_cnt), 64'(H_ACT * V_ACT));
        check("last_xy", 64'({last_x, last_y}), 64'({CW'(H_ACT - 1), CW'(V_ACT - 1)}));
      end
      armed   = oLocked;
      pix_cnt = 0;
    end
    if (oValid) begin
      if (pix_cnt == 0) check("first_xy", 64'({oX, oY}), 64'(0));
      if (map_mode) begin
        check("map_r", 64'(oRed), 64'(8'(oX + CW'(X_START))));
        check("map_g", 64'(oGreen), 64'(8'(oY + CW'(Y_START))));
      end
      pix_cnt++;
      last_x = oX;
      last_y = oY;
    end
  endtask

  task automatic tick(input logic rst_n, input logic hs, input logic vs,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clk);
    if (have_exp) begin
      monitor();
      check("pix", 64'({oValid, oX, oY, oRed, oGreen, oBlue}),
                   64'({e_valid, e_x, e_y, e_r, e_g, e_b}));
      check("status", 64'({oLocked, oLockLost, oFrameStart, oLineLen, oFrameLines}),
                      64'({e_locked, e_lost, e_fs, e_len, e_lines}));
    end
    iRST_N = rst_n; iVGA_H_SYNC = hs; iVGA_V_SYNC = vs;
    iVGA_R = r; iVGA_G = g; iVGA_B = b;
    model_step(rst_n, hs, vs, r, g, b);
    have_exp = 1'b1;
  endtask

  task automatic tick_rand(input logic rst_n, input logic hs, input logic vs);
    logic [23:0] rgb;
    rgb = 24'($urandom);
    tick(rst_n, hs, vs, rgb[23:16], rgb[15:8], rgb[7:0]);
  endtask

  // Lines l0..l1-1 of a frame; line bad_idx is one clock longer
  task automatic drive_lines(input int l0, input int l1, input int len, input int hs_low,
                             input int bad_idx);
    for (int li = l0; li < l1; li++) begin
      for (int k = 0; k < ((li == bad_idx) ? len + 1 : len); k++) begin
        logic hs, vs;
        hs = (k < hs_low) ? 1'b0 : 1'b1;
        vs = (li < VS_LOW) ? 1'b0 : 1'b1;
        if (map_mode) tick(1'b1, hs, vs, 8'(k), 8'(li), 8'($urandom));
        else tick_rand(1'b1, hs, vs);
      end
    end
  endtask

  task automatic nom_frame(input int bad_idx);
    drive_lines(0, NOM_LINES, NOM_LEN, NOM_HS, bad_idx);
  endtask

  initial begin
    int lost0;
    iRST_N = 1'b0; iVGA_H_SYNC = 1'b1; iVGA_V_SYNC = 1'b1;
    iVGA_R = '0; iVGA_G = '0; iVGA_B = '0;

    // Reset with random inputs, then idle with no syncs
    for (int i = 0; i < 5; i++) tick_rand(1'b0, 1'($urandom), 1'($urandom));
    for (int i = 0; i < 40; i++) tick_rand(1'b1, 1'b1, 1'b1);
    check("nolock", 64'(oLocked), 64'(0));

    // Nominal lock with coordinate-mapped pixel data
    map_mode = 1'b1;
    nom_frame(-1);
    check("prelock", 64'(oLocked), 64'(0));
    nom_frame(-1);
    check("lock_nom", 64'(oLocked), 64'(1));
    check("linelen", 64'(oLineLen), 64'(NOM_LEN));
    check("framelines", 64'(oFrameLines), 64'(NOM_LINES));
    nom_frame(-1);
    map_mode = 1'b0;
    nom_frame(-1);
    nom_frame(-1);

    // One long line while locked
    lost0 = lost_cnt;
    nom_frame($urandom_range(0, NOM_LINES - 2));
    check("bad_lost", 64'(lost_cnt - lost0), 64'(1));
    check("bad_unlock", 64'(oLocked), 64'(0));
    nom_frame(-1);
    check("bad_relock_wait", 64'(oLocked), 64'(0));
    nom_frame(-1);
    check("bad_relock", 64'(oLocked), 64'(1));

    // H-sync held high until the position counter saturates
    lost0 = lost_cnt;
    for (int i = 0; i < 2100; i++) tick_rand(1'b1, 1'b1, 1'b1);
    check("sat_lost", 64'(lost_cnt - lost0), 64'(1));
    check("sat_unlock", 64'(oLocked), 64'(0));

    // Short frame during measurement never locks
    locked_seen = 1'b0;
    drive_lines(0, Y_END - 2, NOM_LEN, NOM_HS, -1);
    nom_frame(-1);
    check("short_nolock", 64'(locked_seen), 64'(0));
    nom_frame(-1);
    nom_frame(-1);
    check("short_relock", 64'(oLocked), 64'(1));

    // Reset mid-frame while locked
    drive_lines(0, 5, NOM_LEN, NOM_HS, -1);
    lost0 = lost_cnt;
    tick_rand(1'b0, 1'b1, 1'b1);
    tick_rand(1'b0, 1'b1, 1'b1);
    drive_lines(5, NOM_LINES, NOM_LEN, NOM_HS, -1);
    check("rst_lost", 64'(lost_cnt - lost0), 64'(0));
    check("rst_unlock", 64'(oLocked), 64'(0));
    nom_frame(-1);
    check("rst_relock_wait", 64'(oLocked), 64'(0));
    nom_frame(-1);
    check("rst_relock", 64'(oLocked), 64'(1));

    // Random geometry segments, some below the minimum active size
    for (int s = 0; s < 10; s++) begin
      int len, nl, hsl;
      len = $urandom_range(X_END - 1, X_END + 8);
      nl  = $urandom_range(Y_END - 1, Y_END + 3);
      hsl = $urandom_range(1, 4);
      for (int f = 0; f < 3; f++) drive_lines(0, nl, len, hsl, -1);
    end

    for (int i = 0; i < 4; i++) tick_rand(1'b1, 1'b1, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Receive side of the team's VGA timing: accepts a parallel VGA stream (active-low H/V sync plus 8-bit RGB) in the pixel clock domain and recovers pixel coordinates. Measures line length and frame height and locks when timing is stable. While locked, emits registered per-pixel RGB with X/Y and a valid strobe for frame grabbers, loopback checkers and camera-path capture.

## Interface
- H_ACT, 640: active pixels per line.
- V_ACT, 480: active lines per frame.
- X_START, 143: sample position (from the H-sync falling edge) of the first active pixel.
- Y_START, 34: line index (from the frame-start line) of the first active line.
- CW, 11: width of the position counter, line counter, oX, oY, oLineLen and oFrameLines.

Ports:
- iCLK  in  1  pixel clock; single clock domain.
- iRST_N  in  1  reset, synchronous, active-low.
- iVGA_H_SYNC  in  1  horizontal sync, active low.
- iVGA_V_SYNC  in  1  vertical sync, active low.
- iVGA_R / iVGA_G / iVGA_B  in  8 each  pixel data, sampled every clock.
- oRed / oGreen / oBlue  out  8 each  registered pixel data; 0 when oValid=0.
- oX  out  CW  active-area column; 0 when oValid=0.
- oY  out  CW  active-area row; 0 when oValid=0.
- oValid  out  1  pixel is inside the active window and the block is locked.
- oFrameStart  out  1  one-cycle pulse at each frame start while locked.
- oLocked  out  1  lock status.
- oLockLost  out  1  one-cycle pulse when lock drops for any reason other than reset.
- oLineLen  out  CW  locked line length in clocks.
- oFrameLines  out  CW  locked frame height in lines.

## Operation
- **H-sync edge:** registered copy hs_q. A line edge (LE) occurs when iVGA_H_SYNC=0 and hs_q=1.
- **Sample position p:** p=0 on the LE sample; +1 every clock after that; saturates at 2^CW−1.
- **Line length:** measured at each LE as p(previous sample)+1.
- **Frame start (FS):** V-sync is sampled only on LE samples into vs_q. An FS is an LE with iVGA_V_SYNC=0 and vs_q=1.
- **Line index l:** l=0 on the FS line; +1 at each other LE; saturates at 2^CW−1. Frame height at an FS is l(previous line)+1.
- **Lock FSM** (reference registers ref_len and ref_lines):
  - IDLE: reset state. On FS go to MEAS; ref_len becomes invalid.
  - MEAS: the first LE after FS loads ref_len. Each later LE compares the line length to ref_len; a mismatch goes to IDLE.
  - MEAS exit at the next FS: load ref_lines. Go to LOCKED if ref_len ≥ X_START+H_ACT and ref_lines ≥ Y_START+V_ACT; otherwise go to IDLE.
  - LOCKED: any LE with line length ≠ ref_len, any FS with height ≠ ref_lines, or p reaching saturation goes to IDLE and pulses oLockLost.
  - The MEAS check also runs on the LE that is the FS.
  - IDLE/MEAS timeout: p saturation goes to IDLE without an oLockLost pulse.
- **Pixel path:**
  - Condition: LOCKED, X_START ≤ p < X_START+H_ACT, and Y_START ≤ l < Y_START+V_ACT.
  - When the condition holds, the next clock gives oValid=1, oX=p−X_START, oY=l−Y_START, and RGB equal to that sample's inputs.
  - Otherwise oValid, oX, oY and RGB are all 0.
  - The pixel-path check uses the FSM state before the current sample's update. An unlocking sample therefore produces no valid output.
- **Status outputs:** oLineLen and oFrameLines show ref_len and ref_lines while LOCKED and 0 otherwise.
- **oFrameStart:** pulses on the FS that enters LOCKED and on every FS while LOCKED. It is not asserted on an FS that causes unlock.
- **Width:** all arithmetic is unsigned CW-bit. Saturated counters never wrap.

## Timing
- **Reset:** iRST_N=0 at an edge clears all outputs to 0, the FSM to IDLE, hs_q and vs_q to 1, and the counters to 0. Reset mid-frame drops lock with no oLockLost pulse. Re-lock always takes a full MEAS frame.
- **Latency:**
  - Pixel path: input sample at edge t appears on the outputs after edge t+1 (1 cycle).
  - oLocked: rises 1 cycle after the FS sample that ends MEAS.
  - oLockLost: pulses 1 cycle after the offending sample; oLocked falls in the same cycle.
- **Minimum lock time:** clocks to first FS + one full frame.
- **LE without FS:** line handling only. FS while in IDLE enters MEAS even mid-line.
- **Sync held low:** continuous low produces no further edges and p saturates.
- **No back-pressure:** the consumer must accept one pixel per clock.

## Test plan
1. **Reset:** hold iRST_N=0 for 5 clocks with random inputs → every output is 0; oLocked stays 0 with no syncs.
2. **Nominal lock:** 800-clock lines (96 low), 525-line frames (2 low). oLocked rises 1 cycle after the second FS. oLineLen=800, oFrameLines=525. Exactly 307200 oValid per frame. First valid pixel has oX=0, oY=0; last has oX=639, oY=479; one oFrameStart per frame.
3. **Pixel mapping:** drive iVGA_R=p[7:0], iVGA_G=l[7:0] → every valid output has oRed=(oX+143)[7:0] and oGreen=(oY+34)[7:0] with 1-cycle latency.
4. **Bad line while locked:** one 801-clock line → oLockLost 1-cycle pulse, oLocked=0, no further oValid. Re-lock occurs exactly at the second FS after that.
5. **Sync loss and short frame:** hold H-sync high while locked → unlock when p saturates at 2047. Separately, a 400-line frame in MEAS → no lock; oLocked stays 0.
6. **Reset mid-frame:** assert iRST_N=0 mid-frame while locked → all outputs 0 next cycle, no oLockLost pulse. After release, lock returns at the second FS.
